// File: rtl/bitgen_if.sv
// Request/result channel of the bitgen word generator.
// The master drives requests and the result ready; the slave (bitgen) answers.
interface bitgen_if;
  logic        din_valid;
  logic        din_ready;
  logic [2:0]  din_func;
  logic [6:0]  din_count;
  logic        dout_valid;
  logic        dout_ready;
  logic [63:0] dout_data;

  modport master (
    output din_valid, din_func, din_count, dout_ready,
    input  din_ready, dout_valid, dout_data
  );

  modport slave (
    input  din_valid, din_func, din_count, dout_ready,
    output din_ready, dout_valid, dout_data
  );
endinterface

// File: rtl/bitgen.sv
// bitgen: builds the canonical 64-bit word whose bitcnt result (same function
// code) equals the requested count. The word is grown STEP bit positions per
// BUSY cycle, so latency is max(1, ceil(n/STEP)) BUSY cycles.
module bitgen #(
  parameter int STEP = 8
) (
  input  logic     clk,
  input  logic     resetn,
  bitgen_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [6:0]  STEP_W = 7'(STEP);
  localparam logic [63:0] ONES   = {64{1'b1}};

  typedef struct packed {
    logic [2:0] func;
    logic [6:0] count;
  } req_t;

  logic [1:0]  state, state_nxt;
  logic [63:0] acc, acc_step, seed;
  logic [6:0]  rem, n_sat, k;
  logic [2:0]  func;
  logic        din_ready_q, dout_valid_q;
  logic        accept;
  req_t        req;

  assign req    = '{func: bus.din_func, count: bus.din_count};
  assign accept = (state == IDLE) && bus.din_valid && din_ready_q;

  // Saturate the requested count to the function's word width; unused codes force 0.
  always_comb begin
    n_sat = req.count;
    if (req.func[2:1] == 2'b11)
      n_sat = 7'd0;
    else if (req.func[0] && (req.count > 7'd32))
      n_sat = 7'd32;
    else if (req.count > 7'd64)
      n_sat = 7'd64;
  end

  // Starting word: the marker bit for clz/ctz, empty for pcnt and unused codes.
  always_comb begin
    case (req.func)
      3'b000:         seed = 64'h8000_0000_0000_0000;
      3'b001:         seed = 64'h0000_0000_8000_0000;
      3'b010, 3'b011: seed = 64'h0000_0000_0000_0001;
      default:        seed = 64'd0;
    endcase
  end

  // One BUSY step: move the marker (or grow the run of ones) by k positions.
  always_comb begin
    k = (rem < STEP_W) ? rem : STEP_W;
    case (func[2:1])
      2'b00:   acc_step = acc >> k;
      2'b01:   acc_step = acc << k;
      2'b10:   acc_step = (acc << k) | ~(ONES << k);
      default: acc_step = acc;
    endcase
    if (func[0])
      acc_step[63:32] = 32'd0;
  end

  // Next-state logic; the spare encoding falls back to IDLE.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = accept ? BUSY : IDLE;
      BUSY:    state_nxt = (rem <= STEP_W) ? DONE : BUSY;
      DONE:    state_nxt = bus.dout_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, registered handshake flags and the datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      din_ready_q  <= 1'b0;
      dout_valid_q <= 1'b0;
      acc          <= 64'd0;
      rem          <= 7'd0;
      func         <= 3'd0;
    end else begin
      state        <= state_nxt;
      din_ready_q  <= (state_nxt == IDLE);
      dout_valid_q <= (state_nxt == DONE);
      if (accept) begin
        acc  <= seed;
        rem  <= n_sat;
        func <= req.func;
      end else if (state == BUSY) begin
        acc <= acc_step;
        rem <= rem - k;
      end
    end
  end

  assign bus.din_ready  = din_ready_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_data  = acc;

endmodule
